// File: rtl/dispatch_queue_if.sv
// Packet type and handshake bundle between the front end, the dispatch queue and the core.
package dispatch_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } dispatch_packet_r10k_t;

endpackage

interface dispatch_queue_if #(
  parameter int unsigned N_WAY = 3,
  parameter int unsigned DEPTH = 16
);
  import dispatch_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  dispatch_packet_r10k_t [N_WAY-1:0] in_packet;
  logic [N_WAY-1:0]                  in_branch;
  logic                              in_ready;
  logic                              flush;
  logic [N_WAY-1:0]                  dispatched;
  dispatch_packet_r10k_t [N_WAY-1:0] dispatch_out;
  logic [N_WAY-1:0]                  branch_inst;
  logic [CNT_W-1:0]                  count;

  modport master (
    output in_packet, in_branch, flush, dispatched,
    input  in_ready, dispatch_out, branch_inst, count
  );

  modport slave (
    input  in_packet, in_branch, flush, dispatched,
    output in_ready, dispatch_out, branch_inst, count
  );

endinterface

// File: rtl/dispatch_queue.sv
// Circular instruction buffer: compacts up to N_WAY decoded packets per cycle and presents
// the oldest N_WAY in program order. Define BRANCH_STOP_EN to end each group at its first branch.
`ifndef N_WAY
`define N_WAY 3
`endif

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned N_WAY = `N_WAY,
  parameter int unsigned DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  dispatch_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  dispatch_packet_r10k_t             r_entry [DEPTH];
  logic [DEPTH-1:0]                  r_branch;
  logic [PTR_W-1:0]                  r_head;
  logic [PTR_W-1:0]                  r_tail;
  logic [CNT_W-1:0]                  r_count;

  logic                              w_in_ready;
  logic                              w_accept;
  dispatch_packet_r10k_t [N_WAY-1:0] w_out;
  logic [N_WAY-1:0]                  w_br;
  logic [CNT_W-1:0]                  w_enq_n;
  logic [CNT_W-1:0]                  w_deq_n;
  logic [N_WAY-1:0]                  w_wr_en;
  logic [PTR_W-1:0]                  w_wr_idx [N_WAY];

  // Registered count only, so dispatched never reaches in_ready combinationally.
  assign w_in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(N_WAY);
  assign w_accept   = w_in_ready && !bus.flush;

  // Oldest-first read window straight from storage.
  always_comb begin : read_window
    logic [PTR_W-1:0] w_idx;
    logic             w_stop;
    w_out  = '0;
    w_br   = '0;
    w_idx  = '0;
    w_stop = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      w_idx          = r_head + PTR_W'(i);
      w_out[i]       = r_entry[w_idx];
      w_out[i].valid = (CNT_W'(i) < r_count) && !w_stop;
      w_br[i]        = w_out[i].valid && r_branch[w_idx];
`ifdef BRANCH_STOP_EN
      w_stop         = w_stop | w_br[i];
`endif
    end
  end

  // Dequeue count is the run of leading accepted lanes.
  always_comb begin : dequeue_count
    logic w_run;
    w_deq_n = '0;
    w_run   = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      w_run   = w_run & bus.dispatched[i] & w_out[i].valid;
      w_deq_n = w_deq_n + CNT_W'(w_run);
    end
  end

  // Compact valid input lanes onto consecutive slots from tail.
  always_comb begin : enqueue_map
    w_enq_n  = '0;
    w_wr_en  = '0;
    w_wr_idx = '{default: '0};
    for (int i = 0; i < N_WAY; i++) begin
      w_wr_idx[i] = r_tail + PTR_W'(w_enq_n);
      w_wr_en[i]  = w_accept && bus.in_packet[i].valid;
      w_enq_n     = w_enq_n + CNT_W'(w_wr_en[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Entry payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (w_wr_en[i]) begin
        r_entry[w_wr_idx[i]]  <= bus.in_packet[i];
        r_branch[w_wr_idx[i]] <= bus.in_branch[i];
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.dispatch_out = w_out;
  assign bus.branch_inst  = w_br;
  assign bus.count        = r_count;

endmodule
